instr_fetch_unit: RTL and testbench

Front end of the MIPS core, directly upstream of the opcode decoder. It holds the PC and fetches one instruction at a time over a variable-latency req/ack instruction-memory port. It presents the instruction and its OpCode field to the decoder until the datapath retires it. On retire it computes the next PC from the decoder's Jump/Branch outputs and the ALU Zero flag.

---
 rtl/mips_defs.sv | 31 +++
 rtl/next_pc_logic.sv | 28 ++
 rtl/instr_fetch_unit.sv | 94 +++++++++
 tb/tb_instr_fetch_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared MIPS front-end definitions: opcodes, branch kinds, fetch FSM states
// and the branch-offset helper used by next-PC logic.
package mips_defs;

    localparam logic [5:0] OP_RT   = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_EQ   = 2'b01,
        BR_NE   = 2'b10
    } branch_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_REQ   = 2'b01,
        ST_VALID = 2'b10
    } fetch_state_e;

    // Word offset of a branch immediate, sign-extended and scaled to bytes.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection: jump, taken beq/bne, or sequential PC+4.
module next_pc_logic
    import mips_defs::*;
(
    input  logic [31:0] PC,
    input  logic [31:0] Instr,
    input  logic        Jump,
    input  logic [1:0]  Branch,
    input  logic        Zero,
    output logic [31:0] next_pc,
    output logic [31:0] PcPlus4
);

    logic br_taken;

    assign PcPlus4  = PC + 32'd4;
    assign br_taken = ((Branch == BR_EQ) && Zero) || ((Branch == BR_NE) && !Zero);

    // Jump wins over any branch encoding the decoder may present alongside it.
    always_comb begin
        next_pc = PcPlus4;
        if (Jump)
            next_pc = {PcPlus4[31:28], Instr[25:0], 2'b00};
        else if (br_taken)
            next_pc = PcPlus4 + branch_offset(Instr[15:0]);
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: holds PC, fetches over a req/ack port and
// presents the instruction to the decoder until the datapath retires it.
module instr_fetch_unit
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic                 imem_ack,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          Instr,
    output logic [5:0]           OpCode,
    output logic                 instr_valid,
    output logic [31:0]          PC,
    output logic [31:0]          PcPlus4,
    input  logic                 retire,
    input  logic                 Jump,
    input  logic [1:0]           Branch,
    input  logic                 Zero,
    output logic [CNT_WIDTH-1:0] retired_cnt
);

    fetch_state_e         state_q;
    logic [31:0]          pc_q;
    logic [31:0]          instr_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 req_q;
    logic                 valid_q;
    logic [31:0]          next_pc;

    next_pc_logic u_next_pc (
        .PC      (pc_q),
        .Instr   (instr_q),
        .Jump    (Jump),
        .Branch  (Branch),
        .Zero    (Zero),
        .next_pc (next_pc),
        .PcPlus4 (PcPlus4)
    );

    // req/valid are registered alongside the state so every output is Moore.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_REQ;
                    req_q   <= 1'b1;
                end
                ST_REQ: begin
                    if (imem_ack) begin
                        instr_q <= imem_rdata;
                        state_q <= ST_VALID;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                ST_VALID: begin
                    if (retire) begin
                        pc_q    <= next_pc;
                        cnt_q   <= cnt_q + CNT_WIDTH'(1);
                        state_q <= ST_REQ;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign Instr       = instr_q;
    assign OpCode      = instr_q[31:26];
    assign instr_valid = valid_q;
    assign PC          = pc_q;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: two instances (default counter at
// RESET_PC 0, and a 2-bit counter at 0xF000_0040) checked against a model.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ack[2];
    logic [31:0] rdata[2];
    logic        retire[2];
    logic        jump[2];
    logic [1:0]  br[2];
    logic        zero[2];

    logic        req[2];
    logic        vld[2];
    logic [31:0] addr[2];
    logic [31:0] instr[2];
    logic [31:0] pc[2];
    logic [31:0] pc4[2];
    logic [5:0]  opc[2];
    logic [31:0] cnt[2];
    logic [31:0] cnt_a;
    logic [1:0]  cnt_b;

    assign cnt[0] = cnt_a;
    assign cnt[1] = {30'd0, cnt_b};

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(32)) dut_a (
        .clk(clk), .rst(rst),
        .imem_req(req[0]), .imem_addr(addr[0]), .imem_ack(ack[0]), .imem_rdata(rdata[0]),
        .Instr(instr[0]), .OpCode(opc[0]), .instr_valid(vld[0]), .PC(pc[0]), .PcPlus4(pc4[0]),
        .retire(retire[0]), .Jump(jump[0]), .Branch(br[0]), .Zero(zero[0]),
        .retired_cnt(cnt_a)
    );

    instr_fetch_unit #(.RESET_PC(32'hF000_0040), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst),
        .imem_req(req[1]), .imem_addr(addr[1]), .imem_ack(ack[1]), .imem_rdata(rdata[1]),
        .Instr(instr[1]), .OpCode(opc[1]), .instr_valid(vld[1]), .PC(pc[1]), .PcPlus4(pc4[1]),
        .retire(retire[1]), .Jump(jump[1]), .Branch(br[1]), .Zero(zero[1]),
        .retired_cnt(cnt_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h expected %h", nm, d, act, exp);
        end
    endtask

    // Behavioural model: phase of each unit (0 idle, 1 waiting on memory,
    // 2 holding an instruction), its PC, instruction and retire count.
    logic [31:0] RPC[2];
    logic [31:0] CMASK[2];
    int          m_phase[2];
    logic [31:0] m_pc[2];
    logic [31:0] m_instr[2];
    logic [31:0] m_cnt[2];
    bit          m_live = 1'b0;

    initial begin
        RPC[0] = 32'h0000_0000; CMASK[0] = 32'hFFFF_FFFF;
        RPC[1] = 32'hF000_0040; CMASK[1] = 32'h0000_0003;
    end

    function automatic logic [31:0] target(input logic [31:0] p, input logic [31:0] ins,
                                           input logic j, input logic [1:0] b, input logic z);
        logic [31:0]        seq;
        logic signed [31:0] off;
        seq = p + 32'd4;
        off = 32'($signed(ins[15:0]));
        if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
        if ((b == 2'd1 && z) || (b == 2'd2 && !z)) return seq + 32'(off * 4);
        return seq;
    endfunction

    always @(posedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_phase[d] = 0; m_pc[d] = RPC[d]; m_instr[d] = 32'd0; m_cnt[d] = 32'd0;
            end else if (m_phase[d] == 0) begin
                m_phase[d] = 1;
            end else if (m_phase[d] == 1) begin
                if (ack[d]) begin m_instr[d] = rdata[d]; m_phase[d] = 2; end
            end else if (retire[d]) begin
                m_pc[d]    = target(m_pc[d], m_instr[d], jump[d], br[d], zero[d]);
                m_cnt[d]   = (m_cnt[d] + 32'd1) & CMASK[d];
                m_phase[d] = 1;
            end
        end
        if (rst) m_live = 1'b1;
    end

    always @(negedge clk) begin
        if (m_live) begin
            for (int d = 0; d < 2; d++) begin
                chk("req", d, req[d], m_phase[d] == 1);
                chk("valid", d, vld[d], m_phase[d] == 2);
                chk("pc", d, pc[d], m_pc[d]);
                chk("pcplus4", d, pc4[d], m_pc[d] + 32'd4);
                chk("instr", d, instr[d], m_instr[d]);
                chk("opcode", d, opc[d], m_instr[d] >> 26);
                chk("cnt", d, cnt[d], m_cnt[d]);
                if (m_phase[d] == 1) chk("addr", d, addr[d], m_pc[d]);
            end
        end
    end

    // Drivers: called and returning on a falling edge.
    task automatic fetch(input int d, input int waits, input logic [31:0] w);
        int n = 0;
        while (!req[d] && n < 50) begin @(negedge clk); n++; end
        if (!req[d]) begin chk("fetch_timeout", d, 0, 1); return; end
        repeat (waits) begin
            chk("wait_req", d, req[d], 1);
            @(negedge clk);
        end
        ack[d] = 1'b1; rdata[d] = w;
        @(negedge clk);
        ack[d] = 1'b0; rdata[d] = 32'd0;
    endtask

    task automatic do_retire(input int d, input logic j, input logic [1:0] b, input logic z);
        int n = 0;
        while (!vld[d] && n < 50) begin @(negedge clk); n++; end
        if (!vld[d]) begin chk("retire_timeout", d, 0, 1); return; end
        retire[d] = 1'b1; jump[d] = j; br[d] = b; zero[d] = z;
        @(negedge clk);
        retire[d] = 1'b0; jump[d] = 1'b0; br[d] = 2'd0; zero[d] = 1'b0;
    endtask

    initial begin
        int c0;
        int n;
        logic [31:0] a;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            ack[d] = 0; rdata[d] = 0; retire[d] = 0; jump[d] = 0; br[d] = 0; zero[d] = 0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 0, req[0], 0);
        chk("rst_valid", 0, vld[0], 0);
        chk("rst_opcode", 0, opc[0], 0);
        chk("rst_pc_b", 1, pc[1], 32'hF000_0040);
        rst = 1'b0;

        // Zero-wait memory: 0x0, 0x4, 0x8 at two cycles each, then 0xC.
        n = 0;
        while (!req[0] && n < 10) begin @(negedge clk); n++; end
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            a = 32'(i * 4);
            chk("seq_addr", 0, addr[0], a);
            fetch(0, 0, 32'h2000_0000);
            do_retire(0, 0, 2'd0, 0);
        end
        chk("seq_cnt3", 0, cnt[0], 32'd3);
        chk("seq_cycles", 0, 32'(cyc - c0), 32'd6);
        fetch(0, 0, 32'h2000_0000);
        do_retire(0, 0, 2'd0, 0);

        // beq -2 from 0x10: taken -> 0x0C, then back to 0x10, not taken -> 0x14.
        chk("br_pc", 0, pc[0], 32'h10);
        fetch(0, 0, 32'h1000_FFFE);
        do_retire(0, 0, 2'd1, 1);
        chk("beq_taken", 0, pc[0], 32'h0C);
        fetch(0, 0, 32'h1000_0001);
        do_retire(0, 0, 2'd1, 0);
        fetch(0, 0, 32'h1000_FFFE);
        do_retire(0, 0, 2'd1, 0);
        chk("beq_not_taken", 0, pc[0], 32'h14);

        // Five wait states, then a stray ack while holding the instruction.
        fetch(0, 5, 32'h1400_0003);
        chk("wait_valid", 0, vld[0], 1);
        ack[0] = 1'b1; rdata[0] = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        ack[0] = 1'b0; rdata[0] = 32'd0;
        chk("stray_ack", 0, instr[0], 32'h1400_0003);
        do_retire(0, 0, 2'd2, 0);
        chk("bne_taken", 0, pc[0], 32'h24);
        chk("cnt_a", 0, cnt[0], 32'd8);

        // Jump beats branch; then jump to the top of memory and wrap.
        fetch(1, 0, 32'h0800_0010);
        chk("jmp_pcplus4", 1, pc4[1], 32'hF000_0044);
        do_retire(1, 1, 2'd1, 1);
        chk("jmp_pc", 1, pc[1], 32'hF000_0040);
        fetch(1, 0, 32'h0BFF_FFFF);
        do_retire(1, 1, 2'd0, 0);
        chk("jmp_top", 1, pc[1], 32'hFFFF_FFFC);
        fetch(1, 0, 32'h2000_0000);
        chk("wrap_pcplus4", 1, pc4[1], 32'h0);
        do_retire(1, 0, 2'd0, 0);
        chk("wrap_pc", 1, pc[1], 32'h0);
        chk("cnt_ones", 1, cnt[1], 32'd3);
        fetch(1, 0, 32'h2000_0000);
        do_retire(1, 0, 2'd0, 0);
        chk("cnt_wrap", 1, cnt[1], 32'd0);

        // Reset while a request is pending.
        chk("pending_req", 0, req[0], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rreq_req", 0, req[0], 0);
        chk("rreq_pc", 0, pc[0], 32'h0);
        chk("rreq_cnt", 0, cnt[0], 32'd0);
        n = 0;
        while (!req[0] && n < 10) begin @(negedge clk); n++; end
        chk("req_after_rst", 0, 32'(n), 32'd1);

        // Reset beats a simultaneous retire.
        fetch(0, 0, 32'h2000_0000);
        do_retire(0, 0, 2'd0, 0);
        chk("pre_cnt", 0, cnt[0], 32'd1);
        fetch(0, 1, 32'h0800_0100);
        rst = 1'b1; retire[0] = 1'b1; jump[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0; retire[0] = 1'b0; jump[0] = 1'b0;
        chk("rret_valid", 0, vld[0], 0);
        chk("rret_req", 0, req[0], 0);
        chk("rret_pc", 0, pc[0], 32'h0);
        chk("rret_cnt", 0, cnt[0], 32'd0);
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
